// File: rtl/modexp_pkg.sv
// modexp_pkg: shared state encoding, default sizes and constants for the
// modular-exponentiation sequencer (modexp_seq) and its exponent bit selector.
package modexp_pkg;

  localparam int WIDTH_DEF = 1024;
  localparam int EXP_W_DEF = 1024;
  localparam int LEN_W_DEF = 11;

  // Montgomery-domain exit operand: Mont(acc, 1) = acc * R^-1 mod M.
  localparam logic [WIDTH_DEF-1:0] ONE = {{(WIDTH_DEF-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    TOMONT   = 4'd1,
    WAIT_TM  = 4'd2,
    SQ       = 4'd3,
    WAIT_SQ  = 4'd4,
    MUL      = 4'd5,
    WAIT_MUL = 4'd6,
    NEXT     = 4'd7,
    FROMMONT = 4'd8,
    WAIT_FM  = 4'd9,
    FIN      = 4'd10
  } state_t;

  // States in which the multiplier start pulse is presented.
  function automatic logic is_issue(input state_t s);
    return (s == TOMONT) || (s == SQ) || (s == MUL) || (s == FROMMONT);
  endfunction

endpackage

// File: rtl/modexp_bitsel.sv
// modexp_bitsel: exponent shift register. On load, E is shifted so that bit
// elen-1 lands on the MSB; each shift moves to the next lower exponent bit.
// The MSB is the current bit, which avoids a wide mux indexed by idx.
module modexp_bitsel
  import modexp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [EXP_W-1:0] e,
  input  logic [LEN_W-1:0] elen,
  output logic             cur_bit
);

  localparam logic [LEN_W-1:0] EXP_W_L = LEN_W'(EXP_W);

  logic [EXP_W-1:0] sh_r;
  logic [LEN_W-1:0] shamt_s;

  // Alignment distance: elen is already clamped to EXP_W by the caller.
  always_comb begin
    shamt_s = EXP_W_L - elen;
  end

  // Load aligned exponent (drops bits at or above elen), then shift left per bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_r <= {EXP_W{1'b0}};
    end else if (load) begin
      sh_r <= e << shamt_s;
    end else if (shift) begin
      sh_r <= {sh_r[EXP_W-2:0], 1'b0};
    end else begin
      sh_r <= sh_r;
    end
  end

  assign cur_bit = sh_r[EXP_W-1];

endmodule

// File: rtl/modexp_seq.sv
// modexp_seq: left-to-right square-and-multiply sequencer for X^E mod M that
// drives an external Montgomery multiplier via start/done.
// Optional build macro: MODEXP_CONST_TIME_EN -- when defined, a multiply is
// issued for every exponent bit and its product is kept only for one bits,
// so the operation count depends on elen alone.
module modexp_seq
  import modexp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int EXP_W = EXP_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_x,
  input  logic [EXP_W-1:0] in_e,
  input  logic [LEN_W-1:0] in_elen,
  input  logic [WIDTH-1:0] in_m,
  input  logic [WIDTH-1:0] in_r,
  input  logic [WIDTH-1:0] in_r2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mult_start,
  output logic [WIDTH-1:0] mult_a,
  output logic [WIDTH-1:0] mult_b,
  output logic [WIDTH-1:0] mult_m,
  input  logic [WIDTH-1:0] mult_result,
  input  logic             mult_done
);

  localparam logic [LEN_W-1:0] EXP_W_L = LEN_W'(EXP_W);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(ONE);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] acc_r, xm_r, mod_r, res_r;
  logic [WIDTH-1:0] a_r, b_r, a_s, b_s;
  logic [LEN_W-1:0] idx_r, elen_s;
  logic             elen_zero_r;
  logic             accept_s, cur_bit_s, take_mul_s;
  logic             mstart_r, busy_r, done_r;
  logic             mstart_s, busy_s, done_s;

  // Clamp the requested exponent length and decide whether a MUL step follows SQ.
  always_comb begin
    elen_s   = (in_elen > EXP_W_L) ? EXP_W_L : in_elen;
    accept_s = (state_r == IDLE) && start;
`ifdef MODEXP_CONST_TIME_EN
    take_mul_s = 1'b1;
`else
    take_mul_s = cur_bit_s;
`endif
  end

  modexp_bitsel #(
    .EXP_W (EXP_W),
    .LEN_W (LEN_W)
  ) u_bitsel (
    .clk     (clk),
    .reset   (reset),
    .load    (accept_s),
    .shift   (state_r == NEXT),
    .e       (in_e),
    .elen    (elen_s),
    .cur_bit (cur_bit_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; multiplier completions are only honoured in WAIT states.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:     if (start) state_s = TOMONT; else state_s = IDLE;
      TOMONT:   state_s = WAIT_TM;
      WAIT_TM:  if (mult_done) state_s = elen_zero_r ? FROMMONT : SQ; else state_s = WAIT_TM;
      SQ:       state_s = WAIT_SQ;
      WAIT_SQ:  if (mult_done) state_s = take_mul_s ? MUL : NEXT; else state_s = WAIT_SQ;
      MUL:      state_s = WAIT_MUL;
      WAIT_MUL: if (mult_done) state_s = NEXT; else state_s = WAIT_MUL;
      NEXT:     if (idx_r == {LEN_W{1'b0}}) state_s = FROMMONT; else state_s = SQ;
      FROMMONT: state_s = WAIT_FM;
      WAIT_FM:  if (mult_done) state_s = FIN; else state_s = WAIT_FM;
      FIN:      state_s = IDLE;
      default:  state_s = IDLE;
    endcase
  end

  // Output decode keyed on the next state so operands and start are registered
  // into the issue cycle; SQ after a product needs no extra idle cycle.
  always_comb begin
    a_s = a_r;
    b_s = b_r;
    case (state_s)
      TOMONT: begin
        a_s = in_x;
        b_s = in_r2;
      end
      SQ: begin
        a_s = acc_r;
        b_s = acc_r;
      end
      MUL: begin
        a_s = mult_result;
        b_s = xm_r;
      end
      FROMMONT: begin
        a_s = acc_r;
        b_s = ONE_W;
      end
      default: begin
        a_s = a_r;
        b_s = b_r;
      end
    endcase
    mstart_s = is_issue(state_s);
    busy_s   = (state_s != IDLE) && (state_s != FIN);
    done_s   = (state_s == FIN);
  end

  // Registered multiplier operands and status outputs; operands only change on
  // entry to an issue state, so they are stable across every wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      mstart_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      a_r      <= a_s;
      b_r      <= b_s;
      mstart_r <= mstart_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  // Datapath: X and R2 go straight into the operand registers at acceptance;
  // M, R (initial acc), idx and the exponent are held locally.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r       <= {WIDTH{1'b0}};
      xm_r        <= {WIDTH{1'b0}};
      mod_r       <= {WIDTH{1'b0}};
      res_r       <= {WIDTH{1'b0}};
      idx_r       <= {LEN_W{1'b0}};
      elen_zero_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r       <= in_r;
            mod_r       <= in_m;
            idx_r       <= elen_s - LEN_W'(1);
            elen_zero_r <= (elen_s == {LEN_W{1'b0}});
          end
        end
        WAIT_TM: begin
          if (mult_done) xm_r <= mult_result;
        end
        WAIT_SQ: begin
          if (mult_done) acc_r <= mult_result;
        end
        WAIT_MUL: begin
          // For a zero bit (only reachable in constant-time builds) the product is dropped.
          if (mult_done && cur_bit_s) acc_r <= mult_result;
        end
        NEXT: begin
          if (idx_r != {LEN_W{1'b0}}) idx_r <= idx_r - LEN_W'(1);
        end
        WAIT_FM: begin
          if (mult_done) begin
            acc_r <= mult_result;
            res_r <= mult_result;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign result     = res_r;
  assign mult_start = mstart_r;
  assign mult_a     = a_r;
  assign mult_b     = b_r;
  assign mult_m     = mod_r;

endmodule

// File: tb/tb_modexp_seq.sv
// tb_modexp_seq: scoreboard bench for modexp_seq with a behavioural Montgomery
// multiplier of random latency and a big-integer golden model.
module tb_modexp_seq;

  localparam int W  = 1024;
  localparam int EW = 1024;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  in_x, in_m, in_r, in_r2;
  logic [EW-1:0] in_e;
  logic [LW-1:0] in_elen;
  logic          busy, done, mult_start, mult_done;
  logic [W-1:0]  result, mult_a, mult_b, mult_m, mult_result;

  always #5 clk = ~clk;

  modexp_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .in_x(in_x), .in_e(in_e), .in_elen(in_elen), .in_m(in_m),
    .in_r(in_r), .in_r2(in_r2),
    .busy(busy), .done(done), .result(result),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b), .mult_m(mult_m),
    .mult_result(mult_result), .mult_done(mult_done)
  );

  typedef struct {
    logic [W-1:0] res;
    int           nstart;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   start_cnt = 0;
  int   stab_err = 0;
  int   cyc = 0;
  int   last_done_cyc = 0;
  int   force_lat = 0;
  bit   kill_mult = 1'b0;
  bit   inject_stray = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (low 128 bits)", name, act[127:0], expv[127:0]);
    end
  endtask

  // Radix-2 Montgomery product a*b*2^-W mod m.
  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] m);
    logic [W+1:0] t;
    t = '0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] m);
    logic [2*W-1:0] p, q;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    q = p % {{W{1'b0}}, m};
    return q[W-1:0];
  endfunction

  function automatic logic [W-1:0] r_mod(input logic [W-1:0] m);
    logic [W:0] big, q;
    big = {1'b1, {W{1'b0}}};
    q = big % {1'b0, m};
    return q[W-1:0];
  endfunction

  function automatic logic [W-1:0] modexp_ref(input logic [W-1:0] x, input logic [W-1:0] e,
                                              input int el, input logic [W-1:0] m);
    logic [W-1:0] r;
    r = 1;
    for (int i = el - 1; i >= 0; i--) begin
      r = mulmod(r, r, m);
      if (e[i]) r = mulmod(r, x, m);
    end
    return r;
  endfunction

  function automatic int exp_starts(input int el, input logic [W-1:0] e);
    int pc;
    pc = 0;
    for (int i = 0; i < el; i++) if (e[i]) pc++;
`ifdef MODEXP_CONST_TIME_EN
    return 2 + 2 * el;
`else
    return 2 + el + pc;
`endif
  endfunction

  // Behavioural multiplier: latches operands on mult_start, answers after 1..20 cycles.
  initial begin : mult_model
    logic [W-1:0] ca, cb, cm, pr;
    int  cnt;
    bit  mbusy;
    mult_done = 1'b0;
    mult_result = '0;
    mbusy = 1'b0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      mult_done = 1'b0;
      if (kill_mult) begin
        mbusy = 1'b0;
      end else if (inject_stray) begin
        mult_done = 1'b1;
        mult_result = {W{1'b1}};
        inject_stray = 1'b0;
      end else if (mbusy) begin
        if (mult_a !== ca || mult_b !== cb || mult_m !== cm) stab_err++;
        cnt--;
        if (cnt == 0) begin
          mult_done = 1'b1;
          mult_result = pr;
          mbusy = 1'b0;
          last_done_cyc = cyc;
        end
      end
      if (mult_start && !kill_mult) begin
        start_cnt++;
        if (!mbusy) begin
          ca = mult_a;
          cb = mult_b;
          cm = mult_m;
          pr = mont(ca, cb, cm);
          cnt = (force_lat != 0) ? force_lat : int'($urandom_range(1, 20));
          mbusy = 1'b1;
        end
      end
    end
  end

  // Monitor: each done pops one expected entry and checks it.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_done: got done=1 with result %0h, expected no done", result[127:0]);
        end else begin
          e = sb_q.pop_front();
          check("result", result, e.res);
          check("mult_start count", start_cnt, e.nstart);
          check("done within 2 cycles of last mult_done",
                ((cyc - last_done_cyc) >= 1 && (cyc - last_done_cyc) <= 2) ? 1 : 0, 1);
          check("busy low with done", busy, 0);
          check("operand stability", stab_err, 0);
        end
      end
    end
  end

  task automatic run_vec(input logic [W-1:0] x, input logic [W-1:0] e, input int elen,
                         input logic [W-1:0] m, input logic [W-1:0] exp_res,
                         input bit repulse, input string name);
    exp_t ent;
    int   el;
    int   k;
    el = (elen > EW) ? EW : elen;
    in_x = x;
    in_e = e;
    in_elen = LW'(elen);
    in_m = m;
    in_r = r_mod(m);
    in_r2 = mulmod(in_r, in_r, m);
    ent.res = exp_res;
    ent.nstart = exp_starts(el, e);
    start_cnt = 0;
    stab_err = 0;
    sb_q.push_back(ent);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    check({name, " busy after start"}, busy, 1);
    // Scramble inputs; the block must run from its latched copies.
    in_x = ~x;
    in_e = ~e;
    in_m = m ^ 2;
    in_r = '0;
    in_r2 = '0;
    in_elen = LW'(3);
    if (repulse) begin
      repeat (2) @(posedge clk);
      #2;
      in_x = 7;
      start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
    end
    k = 0;
    while (sb_q.size() != 0 && k < 60000) begin
      @(posedge clk);
      #2;
      k++;
    end
    check({name, " completes"}, sb_q.size(), 0);
    if (sb_q.size() != 0) sb_q.delete();
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin : stim
    logic [W-1:0] rx, re, rm, rexp;
    int k, bad;
    in_x = '0; in_e = '0; in_elen = '0; in_m = '0; in_r = '0; in_r2 = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset status", {busy, done, mult_start}, 0);
    check("reset result", result, 0);
    check("reset mult_a", mult_a, 0);
    check("reset mult_b", mult_b, 0);
    check("reset mult_m", mult_m, 0);
    reset = 1'b0;
    @(posedge clk);
    #2;

    run_vec(4, 13, 4, 497, 445, 1'b0, "x4_e13");
    run_vec(4, 0, 0, 497, 1, 1'b0, "elen0");
    run_vec(5, 1, 1, 497, 5, 1'b1, "x5_e1_restart");
    run_vec(4, 13 | (1 << 10), 4, 497, 445, 1'b0, "high_bits_ignored");
    force_lat = 1;
    run_vec(4, 13, 2047, 497, 445, 1'b0, "elen_clamp");

    // Reset while waiting on the first square, then a stray mult_done.
    force_lat = 5;
    in_x = 4; in_e = 13; in_elen = LW'(4); in_m = 497;
    in_r = r_mod(497);
    in_r2 = mulmod(in_r, in_r, 497);
    start_cnt = 0;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    k = 0;
    while (start_cnt < 2 && k < 200) begin
      @(posedge clk);
      #2;
      k++;
    end
    check("abort reached square", start_cnt, 2);
    @(posedge clk);
    #2;
    reset = 1'b1;
    kill_mult = 1'b1;
    @(posedge clk);
    #2;
    check("abort status", {busy, done, mult_start}, 0);
    check("abort result", result, 0);
    check("abort mult_a", mult_a, 0);
    check("abort mult_b", mult_b, 0);
    check("abort mult_m", mult_m, 0);
    reset = 1'b0;
    kill_mult = 1'b0;
    inject_stray = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      if (busy || done || mult_start) bad++;
    end
    check("idle after stray mult_done", bad, 0);
    force_lat = 0;
    run_vec(4, 13, 4, 497, 445, 1'b0, "after_reset");

    // Full-width random vector against the big-integer model.
    for (int i = 0; i < W / 32; i++) begin
      rx[i*32 +: 32] = $urandom;
      re[i*32 +: 32] = $urandom;
      rm[i*32 +: 32] = $urandom;
    end
    rm[W-1] = 1'b1;
    rm[0] = 1'b1;
    rx[W-1] = 1'b0;
    rexp = modexp_ref(rx, re, EW, rm);
    run_vec(rx, re, EW, rm, rexp, 1'b0, "random_1024");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
